// File: rtl/sseg_capture.sv
// sseg_capture: recovers the four digits shown on a multiplexed, active-low
// seven-segment display by watching its cathode/anode drive lines.
//
// Each anode/cathode sample is synchronized, qualified for STABLE_CYCLES
// consecutive identical cycles, decoded and staged per digit. Once all four
// digits have been captured the staged frame is committed to the outputs.
//
// Optional feature: define SSEG_CAPTURE_HEX_EN to also decode A..F glyphs.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous active-high reset
//   SSEG_CA  cathodes, active-low, [6:0]=a..g, [7]=dp
//   SSEG_AN  anodes, active-low, [0]=rightmost digit
//   numbers  committed digits, [3:0]=digit0 .. [15:12]=digit3
//   dp       committed decimal points, 1=lit
//   err      committed undecodable-digit flags
//   valid    one-cycle pulse per frame commit
//   stale    no capture for TIMEOUT_CYCLES cycles
module sseg_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SSEG_CA,
  input  logic [3:0]  SSEG_AN,
  output logic [15:0] numbers,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        valid,
  output logic        stale
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, HOLD = 2'd2} state_t;

  // Segment pattern (dp ignored) to {undecodable, nibble}
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h10;
    case (seg)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
`ifdef SSEG_CAPTURE_HEX_EN
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [7:0]       ca_s1, ca_s2, ca_last;
  logic [3:0]       an_s1, an_s2, an_last;
  state_t           state;
  logic [CNT_W-1:0] stable_cnt;
  logic [3:0]       mask;
  logic [15:0]      stage_num;
  logic [3:0]       stage_dp;
  logic [3:0]       stage_err;
  logic [TO_W-1:0]  idle_cnt;

  logic       legal_c;
  logic [1:0] idx_c;
  logic       changed_c;
  logic       capture_c;
  logic [4:0] dec_c;

  // Two-flop synchronizer plus previous-sample register for change detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ca_s1   <= '1;
      ca_s2   <= '1;
      ca_last <= '1;
      an_s1   <= '1;
      an_s2   <= '1;
      an_last <= '1;
    end else begin
      ca_s1   <= SSEG_CA;
      ca_s2   <= ca_s1;
      ca_last <= ca_s2;
      an_s1   <= SSEG_AN;
      an_s2   <= an_s1;
      an_last <= an_s2;
    end
  end

  // Exactly one anode low selects a digit; anything else is illegal
  always_comb begin
    legal_c = 1'b1;
    idx_c   = 2'd0;
    case (an_s2)
      4'b1110: idx_c = 2'd0;
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: legal_c = 1'b0;
    endcase
  end

  assign changed_c = ({an_s2, ca_s2} != {an_last, ca_last});
  assign capture_c = (state == QUAL) && legal_c && !changed_c &&
                     (stable_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign dec_c     = decode(ca_s2[6:0]);

  // Qualification FSM; the sample that enters QUAL counts as the first one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      stable_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_c) begin
            state      <= QUAL;
            stable_cnt <= CNT_W'(1);
          end
        end
        QUAL: begin
          if (!legal_c) begin
            state      <= IDLE;
            stable_cnt <= '0;
          end else if (changed_c) begin
            stable_cnt <= CNT_W'(1);
          end else if (capture_c) begin
            state      <= HOLD;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (changed_c) begin
            state      <= legal_c ? QUAL : IDLE;
            stable_cnt <= legal_c ? CNT_W'(1) : '0;
          end
        end
        default: begin
          state      <= IDLE;
          stable_cnt <= '0;
        end
      endcase
    end
  end

  // Staging, capture mask and frame commit (commit uses pre-capture staging)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_num <= '0;
      stage_dp  <= '0;
      stage_err <= '0;
      mask      <= '0;
      numbers   <= '0;
      dp        <= '0;
      err       <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= (mask == 4'hF);
      if (mask == 4'hF) begin
        numbers <= stage_num;
        dp      <= stage_dp;
        err     <= stage_err;
      end
      if (capture_c) begin
        stage_num[{idx_c, 2'b00} +: 4] <= dec_c[3:0];
        stage_dp[idx_c]                <= ~ca_s2[7];
        stage_err[idx_c]               <= dec_c[4];
      end
      mask <= ((mask == 4'hF) ? 4'h0 : mask) |
              (capture_c ? (4'b0001 << idx_c) : 4'h0);
    end
  end

  // Saturating cycles-since-capture counter driving stale
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (capture_c) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (idle_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + TO_W'(1);
      stale    <= (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: directed frame table, multi-cycle corner sequences and a
// randomized scan compared every cycle against a run-length reference model.
module tb_sseg_capture;

  localparam int unsigned S = 8;
  localparam int unsigned T = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  SSEG_CA = 8'hFF;
  logic [3:0]  SSEG_AN = 4'hF;
  logic [15:0] numbers;
  logic [3:0]  dp;
  logic [3:0]  err;
  logic        valid;
  logic        stale;

  sseg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .SSEG_CA(SSEG_CA), .SSEG_AN(SSEG_AN),
    .numbers(numbers), .dp(dp), .err(err), .valid(valid), .stale(stale)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Glyph table: index i is the digit value the pattern stands for.
  logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic void model_decode(input logic [7:0] ca, output logic [3:0] nib,
                                       output logic bad);
    int lim;
    lim = 10;
`ifdef SSEG_CAPTURE_HEX_EN
    lim = 16;
`endif
    nib = 4'h0;
    bad = 1'b1;
    for (int i = 0; i < lim; i++)
      if ({1'b1, ca[6:0]} == codes[i]) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  endfunction

  logic [11:0] m_d1, m_d2, m_prev, m_smp;
  int          m_run, m_idle, m_dig;
  logic [15:0] m_stage_num, m_numbers;
  logic [3:0]  m_stage_dp, m_stage_err, m_mask, m_dp, m_err, m_nib;
  logic        m_valid, m_stale, m_bad;

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_prev = '1; m_run = 0; m_idle = 0;
    m_stage_num = '0; m_stage_dp = '0; m_stage_err = '0; m_mask = '0;
    m_numbers = '0; m_dp = '0; m_err = '0; m_valid = 1'b0; m_stale = 1'b0;
  endtask

  // A digit is captured when a legal sample has been seen for exactly S cycles in a row
  task automatic model_step();
    m_smp = m_d2;
    m_d2  = m_d1;
    m_d1  = {SSEG_AN, SSEG_CA};
    m_valid = 1'b0;
    if (m_mask == 4'hF) begin
      m_numbers = m_stage_num; m_dp = m_stage_dp; m_err = m_stage_err;
      m_valid = 1'b1; m_mask = 4'h0;
    end
    if (m_smp == m_prev) begin
      if (m_run <= int'(S)) m_run++;
    end else m_run = 1;
    m_prev = m_smp;
    if (m_run == int'(S) && $countones(~m_smp[11:8]) == 1) begin
      m_dig = 0;
      for (int i = 0; i < 4; i++) if (!m_smp[8+i]) m_dig = i;
      model_decode(m_smp[7:0], m_nib, m_bad);
      m_stage_num[4*m_dig +: 4] = m_nib;
      m_stage_dp[m_dig]  = ~m_smp[7];
      m_stage_err[m_dig] = m_bad;
      m_mask[m_dig]      = 1'b1;
      m_idle = 0;
      m_stale = 1'b0;
    end else begin
      if (m_idle < int'(T)) m_idle++;
      m_stale = (m_idle >= int'(T));
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) model_reset();
      else model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input logic [3:0] an, input logic [7:0] ca, input int n);
    SSEG_AN = an;
    SSEG_CA = ca;
    repeat (n) begin
      @(negedge CLK);
      if (valid === 1'b1) vcount++;
      chk("model_cycle", {6'd0, numbers, dp, err, valid, stale},
          {6'd0, m_numbers, m_dp, m_err, m_valid, m_stale});
    end
  endtask

  task automatic dig(input int d, input logic [7:0] ca, input int n);
    hold(~(4'b0001 << d), ca, n);
  endtask

  typedef struct {
    logic [31:0] cas;   // {digit3, digit2, digit1, digit0} cathode bytes
    int          dwell;
    logic [15:0] num;
    logic [3:0]  dpx;
    logic [3:0]  errx;
  } vec_t;

  vec_t tbl [4];
  int   v0;
  logic [3:0] r_an;
  logic [7:0] r_ca;

  initial begin
    tbl[0] = '{32'hF9A4B099, 1000, 16'h1234, 4'b0000, 4'b0000};
    tbl[1] = '{32'h9202F880, 40, 16'h5678, 4'b0100, 4'b0000};
`ifdef SSEG_CAPTURE_HEX_EN
    tbl[2] = '{32'hFF9088C0, 40, 16'h09A0, 4'b0000, 4'b1000};
`else
    tbl[2] = '{32'hFF9088C0, 40, 16'h0900, 4'b0000, 4'b1010};
`endif
    tbl[3] = '{32'h30247940, 40, 16'h3210, 4'b1111, 4'b0000};

    #1 RST = 1'b1;
    #1;
    chk("reset_numbers", 32'(numbers), 32'h0);
    chk("reset_dp", 32'(dp), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_stale", 32'(stale), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Directed frames
    for (int i = 0; i < 4; i++) begin
      v0 = vcount;
      for (int d = 0; d < 4; d++) dig(d, tbl[i].cas[8*d +: 8], tbl[i].dwell);
      chk("tbl_valid_count", vcount - v0, 1);
      chk("tbl_numbers", 32'(numbers), 32'(tbl[i].num));
      chk("tbl_dp", 32'(dp), 32'(tbl[i].dpx));
      chk("tbl_err", 32'(err), 32'(tbl[i].errx));
    end

    // Glitch: last digit held one cycle short of qualification
    v0 = vcount;
    dig(0, 8'h92, 40);
    dig(1, 8'h82, 40);
    dig(2, 8'hF8, 40);
    dig(3, 8'hC0, S - 1);
    hold(4'hF, 8'hFF, 30);
    chk("glitch_no_valid", vcount - v0, 0);
    chk("glitch_numbers_held", 32'(numbers), 32'h3210);
    dig(3, 8'hC0, 40);
    chk("glitch_then_valid", vcount - v0, 1);
    chk("glitch_numbers", 32'(numbers), 32'h0765);

    // Illegal anode pattern parked mid-scan
    v0 = vcount;
    dig(0, 8'h99, 40);
    dig(1, 8'hB0, 40);
    hold(4'b1100, 8'hA4, 500);
    chk("illegal_no_valid", vcount - v0, 0);
    dig(2, 8'hA4, 40);
    dig(3, 8'hF9, 40);
    chk("illegal_valid", vcount - v0, 1);
    chk("illegal_numbers", 32'(numbers), 32'h1234);
    chk("illegal_err", 32'(err), 32'h0);

    // Stale timeout
    hold(4'hF, 8'hFF, 100);
    chk("stale_high", 32'(stale), 32'h1);
    dig(0, 8'hC0, S + 4);         // captured at cycle S+2, two idle cycles since
    chk("stale_cleared", 32'(stale), 32'h0);
    hold(4'hF, 8'hFF, T - 4);     // T-2 idle cycles
    chk("stale_not_yet", 32'(stale), 32'h0);
    hold(4'hF, 8'hFF, 4);         // T+2 idle cycles
    chk("stale_reached", 32'(stale), 32'h1);

    // Reset in the middle of a frame
    dig(0, 8'h80, 40);
    dig(1, 8'h90, 40);
    chk("prereset_numbers", 32'(numbers), 32'h1234);
    SSEG_AN = 4'hF;
    SSEG_CA = 8'hFF;
    RST = 1'b1;
    #1;
    chk("midreset_numbers", 32'(numbers), 32'h0);
    chk("midreset_valid", 32'(valid), 32'h0);
    chk("midreset_stale", 32'(stale), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    v0 = vcount;
    dig(2, 8'hC0, 40);
    dig(3, 8'hF9, 40);
    chk("postreset_partial_no_valid", vcount - v0, 0);
    dig(0, 8'h99, 40);
    dig(1, 8'hB0, 40);
    chk("postreset_valid", vcount - v0, 1);
    chk("postreset_numbers", 32'(numbers), 32'h1034);

    // Randomized scanning against the model
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 6) == 0) r_an = 4'($urandom_range(0, 15));
      else r_an = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r_ca = 8'($urandom_range(0, 255));
      else begin
        r_ca = codes[$urandom_range(0, 15)];
        if ($urandom_range(0, 3) == 0) r_ca[7] = 1'b0;
      end
      hold(r_an, r_ca, $urandom_range(1, 2 * S + 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, cycles without any capture before stale asserts.
REQ-003 SHALL have port CLK  input  1  system clock (100 MHz).
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port SSEG_CA  input  8  cathodes, active-low; [0]=a … [6]=g, [7]=dp.
REQ-006 SHALL have port SSEG_AN  input  4  anodes, active-low; [0]=rightmost digit.
REQ-007 SHALL have port numbers  output  16  reconstructed digits; [3:0]=digit0 … [15:12]=digit3.
REQ-008 SHALL have port dp  output  4  captured decimal points, 1=lit, bit n = digit n.
REQ-009 SHALL have port err  output  4  bit n set when digit n of the committed frame was undecodable.
REQ-010 SHALL have port valid  output  1  one-cycle pulse on each frame commit.
REQ-011 SHALL have port stale  output  1  no capture within TIMEOUT_CYCLES.

Function
REQ-012 SHALL pass SSEG_CA and SSEG_AN through a 2-flop synchronizer; all logic below uses synchronized values.
REQ-013 SHALL treat an anode sample as legal only when exactly one bit is 0; all-ones, or more than one bit 0, SHALL be illegal.
REQ-014 SHALL implement FSM IDLE/QUAL/HOLD: IDLE->QUAL on a legal sample; QUAL counts consecutive cycles with unchanged {anode,cathode}; QUAL->HOLD on count reaching STABLE_CYCLES (capture occurs that cycle); any change or illegal sample in QUAL restarts the count (legal) or returns to IDLE (illegal); HOLD->QUAL/IDLE on any anode or cathode change.
REQ-015 SHALL decode cathode[6:0] ignoring dp: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, with bit7=1); any other pattern is undecodable, staged nibble 4'h0 with error bit set.
REQ-016 SHALL, on capture, write nibble, dp (~SSEG_CA[7]) and error bit into the staging slot of the active digit and set that digit's bit in a 4-bit capture mask; a re-capture of an already-masked digit SHALL overwrite its slot.
REQ-017 SHALL, when the mask becomes 4'hF, on the next cycle copy staging to numbers/dp/err, pulse valid for exactly one cycle, and clear the mask.
REQ-018 SHALL hold numbers/dp/err unchanged between commits; partial frames never reach outputs.
REQ-019 SHALL count cycles since the last capture, saturating; stale SHALL assert when the count reaches TIMEOUT_CYCLES and deassert on the next capture.
REQ-020 SHALL give total latency from final-digit input change to valid = 2 (sync) + STABLE_CYCLES + 1 cycles.

Reset
REQ-021 SHALL on RST asynchronously force: FSM=IDLE, counters=0, mask=0, staging=0, synchronizers=all-ones, numbers=16'h0000, dp=0, err=0, valid=0, stale=0.
REQ-022 SHALL discard any partial frame when RST asserts mid-capture; first commit after release requires four fresh captures.

Configuration
REQ-023 SHALL, with SSEG_CAPTURE_HEX_EN defined, additionally decode A=88,b=83,C=C6,d=A1,E=86,F=8E to nibbles A–F without error.
REQ-024 SHALL, without SSEG_CAPTURE_HEX_EN, treat those six patterns as undecodable per REQ-015.

Verification
REQ-025 Scan "1234" (AN 1110,1101,1011,0111; CA F9… mapped digit0=4: 99,B0,A4,F9), 1000 cycles per digit -> valid pulse, numbers=16'h1234, err=0, dp=0.
REQ-026 Glitch: legal digit held STABLE_CYCLES-1 cycles then changed -> no capture, mask unchanged, no valid.
REQ-027 Illegal anode 4'b1100 held 500 cycles inside a scan -> ignored; frame still commits correctly once all four digits captured.
REQ-028 Digit1 cathode 8'h88 -> with SSEG_CAPTURE_HEX_EN numbers[7:4]=4'hA, err=0; without it numbers[7:4]=0, err=4'b0010.
REQ-029 Stop scanning (AN=4'hF) with TIMEOUT_CYCLES=64 -> stale high 64 cycles after last capture; resume -> stale low on first capture.
REQ-030 Assert RST after two digits captured -> outputs zero immediately; after release, valid only after four new captures.
